bank_scheduler: RTL

BANK_SCHEDULER -- requirements
Module: bank_scheduler

---
 rtl/bank_scheduler_pkg.sv | 16 +
 rtl/bank_scheduler_rr_arbiter.sv | 34 +++
 rtl/bank_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bank_scheduler_pkg.sv
// Shared types for the bank scheduler: bank index width and scheduler states.
package types_def;

    localparam int unsigned NUM_BANKS = 16;
    localparam int unsigned BANK_W    = 4;

    typedef logic [BANK_W-1:0] bank_id_t;

    typedef enum logic [1:0] {
        RD_MODE,
        WR_MODE,
        TURN_RW,
        TURN_WR
    } sched_mode_t;

endpackage

// File: rtl/bank_scheduler_rr_arbiter.sv
// Round-robin picker: first eligible request after ptr_i, wrapping at the top.
module rr_arbiter
    import types_def::*;
#(
    parameter int unsigned N = types_def::NUM_BANKS
) (
    input  logic [N-1:0] req_i,
    input  bank_id_t     ptr_i,
    input  logic [N-1:0] mask_i,
    output bank_id_t     grant_o,
    output logic         found_o
);

    logic [N-1:0] elig;

    assign elig = req_i & ~mask_i;

    function automatic bank_id_t wrap_idx(input bank_id_t p, input int unsigned k);
        return bank_id_t'((32'(p) + k) % N);
    endfunction

    // Scan ptr+1 .. ptr+N (ptr itself last) and keep the first hit.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (!found_o && elig[wrap_idx(ptr_i, i)]) begin
                found_o = 1'b1;
                grant_o = wrap_idx(ptr_i, i);
            end
        end
    end

endmodule

// File: rtl/bank_scheduler.sv
// Read/write bank scheduler with watermark- and starvation-driven mode switching.
module bank_scheduler
    import types_def::*;
#(
    parameter int unsigned NUM_BANKS    = types_def::NUM_BANKS,
    parameter int unsigned WR_HIGH      = 12,
    parameter int unsigned WR_LOW       = 4,
    parameter int unsigned STARVE_LIMIT = 32,
    parameter int unsigned TURN_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BANKS-1:0] rd_valid,
    input  logic [NUM_BANKS-1:0] wr_valid,
    input  logic [5:0]           wr_count,
    input  logic                 grant_ready,
    output logic                 grant_valid,
    output bank_id_t             grant_bank,
    output logic                 grant_is_write,
    output logic [NUM_BANKS-1:0] bank_pop,
    output logic                 mode
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TURN_W   = $clog2(TURN_CYCLES + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [TURN_W-1:0]   TURN_LAST  = TURN_W'(TURN_CYCLES - 1);

    sched_mode_t          state_q, state_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [TURN_W-1:0]    turn_q, turn_d;
    bank_id_t             rd_ptr_q, rd_ptr_d;
    bank_id_t             wr_ptr_q, wr_ptr_d;
    logic                 grant_valid_q, grant_valid_d;
    bank_id_t             grant_bank_q, grant_bank_d;
    logic                 grant_is_write_q, grant_is_write_d;
    logic                 mode_q, mode_d;

    logic     accept, slot_free;
    logic     rd_any, wr_any, wr_high, wr_low, starve_hit, turn_done;
    logic     rd_exit, wr_exit;
    bank_id_t rd_eff_ptr, wr_eff_ptr;
    bank_id_t rd_idx, wr_idx;
    logic     rd_found, wr_found;

    // A grant presented during reset is dropped, never popped.
    assign accept     = grant_valid_q & grant_ready & ~rst;
    assign slot_free  = ~grant_valid_q | accept;
    assign rd_any     = |rd_valid;
    assign wr_any     = |wr_valid;
    assign wr_high    = wr_count >= 6'(WR_HIGH);
    assign wr_low     = wr_count <= 6'(WR_LOW);
    assign starve_hit = starve_q == STARVE_MAX;
    assign turn_done  = turn_q == TURN_LAST;

    assign rd_exit = wr_high | (~rd_any & wr_any) | starve_hit;
    assign wr_exit = rd_any & ~wr_high & (wr_low | ~wr_any | starve_hit);

    // The pointer moves to the accepted bank in the same cycle, so arbitration
    // already starts after the bank being popped.
    assign rd_eff_ptr = (accept & ~grant_is_write_q) ? grant_bank_q : rd_ptr_q;
    assign wr_eff_ptr = (accept &  grant_is_write_q) ? grant_bank_q : wr_ptr_q;

    rr_arbiter #(.N(NUM_BANKS)) u_rd_arb (
        .req_i   (rd_valid),
        .ptr_i   (rd_eff_ptr),
        .mask_i  (bank_pop),
        .grant_o (rd_idx),
        .found_o (rd_found)
    );

    rr_arbiter #(.N(NUM_BANKS)) u_wr_arb (
        .req_i   (wr_valid),
        .ptr_i   (wr_eff_ptr),
        .mask_i  (bank_pop),
        .grant_o (wr_idx),
        .found_o (wr_found)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RD_MODE;
        else     state_q <= state_d;
    end

    // Next state, turnaround counter and starvation counter.
    always_comb begin
        state_d  = state_q;
        turn_d   = '0;
        starve_d = starve_q;
        unique case (state_q)
            RD_MODE: begin
                if (slot_free && rd_exit) begin
                    state_d  = TURN_RW;
                    starve_d = '0;
                end else if (wr_any && !starve_hit) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            WR_MODE: begin
                if (slot_free && wr_exit) begin
                    state_d  = TURN_WR;
                    starve_d = '0;
                end else if (rd_any && !starve_hit) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            TURN_RW: begin
                if (turn_done) state_d = WR_MODE;
                else           turn_d  = turn_q + 1'b1;
            end
            TURN_WR: begin
                if (turn_done) state_d = RD_MODE;
                else           turn_d  = turn_q + 1'b1;
            end
            default: state_d = RD_MODE;
        endcase
    end

    // Grant, pop, pointer and mode next values.
    // The last turnaround cycle already arbitrates for the new mode so that the
    // first grant lands together with the mode change.
    always_comb begin
        grant_valid_d    = grant_valid_q;
        grant_bank_d     = grant_bank_q;
        grant_is_write_d = grant_is_write_q;
        mode_d           = mode_q;
        rd_ptr_d         = rd_eff_ptr;
        wr_ptr_d         = wr_eff_ptr;
        bank_pop         = '0;
        if (accept) bank_pop[grant_bank_q] = 1'b1;
        if (slot_free) begin
            grant_valid_d = 1'b0;
            unique case (state_q)
                RD_MODE: if (state_d == RD_MODE) begin
                    grant_valid_d    = rd_found;
                    grant_bank_d     = rd_idx;
                    grant_is_write_d = 1'b0;
                end
                WR_MODE: if (state_d == WR_MODE) begin
                    grant_valid_d    = wr_found;
                    grant_bank_d     = wr_idx;
                    grant_is_write_d = 1'b1;
                end
                TURN_RW: if (turn_done) begin
                    grant_valid_d    = wr_found;
                    grant_bank_d     = wr_idx;
                    grant_is_write_d = 1'b1;
                    mode_d           = 1'b1;
                end
                TURN_WR: if (turn_done) begin
                    grant_valid_d    = rd_found;
                    grant_bank_d     = rd_idx;
                    grant_is_write_d = 1'b0;
                    mode_d           = 1'b0;
                end
                default: grant_valid_d = 1'b0;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            turn_q           <= '0;
            starve_q         <= '0;
            rd_ptr_q         <= bank_id_t'(NUM_BANKS - 1);
            wr_ptr_q         <= bank_id_t'(NUM_BANKS - 1);
            grant_valid_q    <= 1'b0;
            grant_bank_q     <= '0;
            grant_is_write_q <= 1'b0;
            mode_q           <= 1'b0;
        end else begin
            turn_q           <= turn_d;
            starve_q         <= starve_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            grant_valid_q    <= grant_valid_d;
            grant_bank_q     <= grant_bank_d;
            grant_is_write_q <= grant_is_write_d;
            mode_q           <= mode_d;
        end
    end

    assign grant_valid    = grant_valid_q;
    assign grant_bank     = grant_bank_q;
    assign grant_is_write = grant_is_write_q;
    assign mode           = mode_q;

endmodule
